// File: rtl/bp_be_pkg.sv
// Shared types and helpers for the accelerator writeback path.
package bp_be_pkg;

  typedef enum logic [1:0] {
    eREADY = 2'd0,
    eSEND  = 2'd1,
    eFENCE = 2'd2
  } wb_state_e;

  function automatic int unsigned beat_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/bsg_counter_up_down.sv
// Saturation-free up/down counter; async active-low reset.
module bsg_counter_up_down #(
  parameter int max_val_p  = 8,
  parameter int init_val_p = 0,
  localparam int width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_o <= width_lp'(init_val_p);
    else            count_o <= count_o + width_lp'(up_i) - width_lp'(down_i);
  end

endmodule

// File: rtl/bp_be_accel_writeback.sv
// Turns DPU result beats into uncached writes at per-destination
// incrementing offsets, bounding the number of un-acked writes.
module bp_be_accel_writeback
  import bp_be_pkg::*;
#(
  parameter int paddr_width_p     = 40,
  parameter int data_width_p      = 128,
  parameter int max_outstanding_p = 8,
  parameter int window_bytes_p    = 4096
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic                     buf_i,
  input  logic                     v_i,
  output logic                     ready_and_o,
  input  logic [paddr_width_p-1:0] dest0_base_i,
  input  logic [paddr_width_p-1:0] dest1_base_i,
  input  logic [1:0]               rewind_i,
  input  logic                     fence_i,
  output logic [paddr_width_p-1:0] wr_addr_o,
  output logic [data_width_p-1:0]  wr_data_o,
  output logic                     wr_buf_o,
  output logic                     wr_v_o,
  input  logic                     wr_ready_and_i,
  input  logic                     ack_v_i,
  output logic                     idle_o,
  output logic                     err_o
);

  localparam int off_w_lp = (window_bytes_p > 1) ? $clog2(window_bytes_p) : 1;
  localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);
  // Offsets are window-sized, so the natural wrap of the adder gives the modulo.
  localparam logic [off_w_lp-1:0] step_lp =
    off_w_lp'(beat_bytes(data_width_p) % window_bytes_p);

  wb_state_e state_r, state_n;
  logic [off_w_lp-1:0] off0_r, off1_r, sel_off;
  logic [cnt_w_lp-1:0] outstanding;
  logic accept, send, ack_ok;

  // Gated by reset so nothing is offered while reset is held.
  assign ready_and_o = reset_n_i & (state_r == eREADY) & ~fence_i
                     & (outstanding < cnt_w_lp'(max_outstanding_p));
  assign accept  = v_i & ready_and_o;
  assign wr_v_o  = (state_r == eSEND);
  assign send    = wr_v_o & wr_ready_and_i;
  assign ack_ok  = ack_v_i & ((outstanding != '0) | send);
  assign idle_o  = (state_r != eSEND) & (outstanding == '0);
  assign sel_off = buf_i ? off1_r : off0_r;

  bsg_counter_up_down #(
    .max_val_p (max_outstanding_p),
    .init_val_p(0)
  ) outstanding_cnt (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .up_i     (send),
    .down_i   (ack_ok),
    .count_o  (outstanding)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eREADY;
      err_o   <= 1'b0;
    end else begin
      state_r <= state_n;
      if (ack_v_i & ~ack_ok) err_o <= 1'b1;
    end
  end

  // A rewind wins over the advance; the accepted beat still used the old offset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      off0_r <= '0;
      off1_r <= '0;
    end else begin
      if (rewind_i[0])          off0_r <= '0;
      else if (accept & ~buf_i) off0_r <= off0_r + step_lp;
      if (rewind_i[1])          off1_r <= '0;
      else if (accept & buf_i)  off1_r <= off1_r + step_lp;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_addr_o <= '0;
      wr_data_o <= '0;
      wr_buf_o  <= 1'b0;
    end else if (accept) begin
      wr_addr_o <= (buf_i ? dest1_base_i : dest0_base_i) + paddr_width_p'(sel_off);
      wr_data_o <= data_i;
      wr_buf_o  <= buf_i;
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      eREADY: if (fence_i) state_n = eFENCE;
              else if (accept) state_n = eSEND;
      eSEND:  if (send) state_n = fence_i ? eFENCE : eREADY;
      eFENCE: if (!fence_i) state_n = eREADY;
      default: state_n = eREADY;
    endcase
  end

endmodule
